vec_packer: RTL and testbench
=============================

// Module: vec_packer
// PURPOSE
//   Stream-to-vector packer: accepts WIDTH-bit samples one per valid/ready beat and
//   assembles 2**SIZE of them into the packed lane vector the max/argmax reduction consumes.
//   Sits between a serial sample source and the max/argmax tree.
//   Double-buffered (fill buffer + output register) so input keeps flowing while a vector waits.
// PARAMETERS
//   WIDTH  8  bits per sample/lane
//   SIZE   2  log2 of lanes per vector; N = 2**SIZE lanes
// PORTS
//   clk      in   1           rising-edge clock
//   rst_n    in   1           asynchronous active-low reset
//   s_valid  in   1           input sample valid
//   s_ready  out  1           packer can accept a sample
//   s_data   in   WIDTH       input sample
//   s_last   in   1           sample closes the current vector early (qualified by s_valid)
//   m_valid  out  1           packed vector valid
//   m_ready  in   1           downstream accepts vector
//   m_data   out  N*WIDTH     lane i = m_data[WIDTH*(i+1)-1 : WIDTH*i]
//   m_count  out  SIZE+1      number of populated lanes, 1..N
// BEHAVIOUR
//   - Beat: s_valid&&s_ready (in), m_valid&&m_ready (out); transfers complete on the clk edge.
//   - Reset (async assert, sync release): m_valid=0, m_data=0, m_count=0, s_ready=1,
//     lane index=0, fill buffer=0, state=FILL. Mid-vector reset discards partial data.
//   - Lane index idx (SIZE bits) selects the fill-buffer lane written by each input beat.
//   - Vector closes on an input beat with idx==N-1 or s_last=1. On close:
//       count=idx+1; lanes above idx are forced to 0 in the packed result;
//       idx returns to 0; fill buffer cleared.
//   - State FILL: s_ready=1.
//       close beat and (m_valid==0 or m_ready==1 this cycle): output register loads
//       {closing sample, buffered lanes} same edge -> m_valid=1 next cycle (latency 1 from
//       last input beat). Stay FILL.
//       close beat and output register occupied and not draining: completed vector kept in
//       fill buffer -> HOLD.
//   - State HOLD: s_ready=0. When m_valid&&m_ready: output register loads held vector
//       and its count at that edge (m_valid stays 1), buffer cleared, -> FILL.
//   - m_valid drops only after m_valid&&m_ready with nothing to reload.
//   - m_data/m_count are stable while m_valid=1 and m_ready=0.
//   - s_data ignored when s_valid=0; s_last ignored unless the beat is taken.
//   - Throughput: one sample/cycle sustained when m_ready is held high; no bubble between
//     back-to-back vectors.
//   - m_valid/m_count/m_data are registered outputs; s_ready is a function of state only.
// TESTING
//   1. WIDTH=8,SIZE=2, m_ready=1, feed 0x11,0x22,0x33,0x44 on 4 cycles -> cycle after 4th beat
//      m_valid=1, m_data=0x44332211, m_count=4.
//   2. Feed 0xAA then 0xBB with s_last=1 -> m_data=0x0000BBAA, m_count=2; next vector starts
//      at lane 0.
//   3. m_ready=0, stream 8 samples 0x01..0x08 -> first vector 0x04030201 held; second fills,
//      state HOLD, s_ready=0; raise m_ready -> 0x08070605 appears next cycle, s_ready=1 after.
//   4. Continuous stream, m_ready=1, 12 samples -> three vectors on consecutive 4-cycle slots,
//      s_ready never low.
//   5. Assert rst_n=0 after 2 samples, release, feed 4 samples 0xF0..0xF3 -> m_valid low
//      through reset; vector = 0xF3F2F1F0, count 4 (stale lanes gone).
//   6. s_last on very first sample 0x5A -> m_data=0x0000005A, m_count=1.

Source files
------------

// File: rtl/vec_packer_if.sv
// Sample-in / vector-out stream bundle for vec_packer.
// The packer takes the slave view; the source/sink driving it takes the master view.
interface vec_packer_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SIZE  = 2
);
  localparam int unsigned N = 2 ** SIZE;

  logic                 s_valid;
  logic                 s_ready;
  logic [WIDTH-1:0]     s_data;
  logic                 s_last;
  logic                 m_valid;
  logic                 m_ready;
  logic [N*WIDTH-1:0]   m_data;
  logic [SIZE:0]        m_count;

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_count
  );

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, m_count
  );
endinterface

// File: rtl/vec_packer.sv
// Stream-to-vector packer: gathers up to 2**SIZE WIDTH-bit samples into one lane vector,
// with a fill buffer in front of a registered output so input can continue while a vector waits.
module vec_packer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SIZE  = 2
) (
  input logic         clk,
  input logic         rst_n,
  vec_packer_if.slave bus
);
  localparam int unsigned N = 2 ** SIZE;

  typedef enum logic [0:0] {StFill, StHold} state_e;

  state_e               state_q, state_d;
  logic [SIZE-1:0]      idx_q, idx_d;
  logic [N*WIDTH-1:0]   buf_q, buf_d;
  logic [SIZE:0]        hold_count_q, hold_count_d;
  logic                 m_valid_q, m_valid_d;
  logic [N*WIDTH-1:0]   m_data_q, m_data_d;
  logic [SIZE:0]        m_count_q, m_count_d;

  logic                 in_beat, close, out_free;
  logic [SIZE:0]        close_count;
  logic [N*WIDTH-1:0]   packed_vec;

  assign bus.s_ready = (state_q == StFill);
  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign bus.m_count = m_count_q;

  assign in_beat     = bus.s_valid && (state_q == StFill);
  assign close       = in_beat && ((idx_q == SIZE'(N - 1)) || bus.s_last);
  assign out_free    = !m_valid_q || bus.m_ready;
  assign close_count = (SIZE + 1)'(idx_q) + (SIZE + 1)'(1);

  // Closing vector: buffered lanes below idx, the new sample at idx, zeros above.
  always_comb begin
    packed_vec = '0;
    for (int i = 0; i < N; i++) begin
      if (SIZE'(i) < idx_q) begin
        packed_vec[i*WIDTH +: WIDTH] = buf_q[i*WIDTH +: WIDTH];
      end else if (SIZE'(i) == idx_q) begin
        packed_vec[i*WIDTH +: WIDTH] = bus.s_data;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    buf_d        = buf_q;
    hold_count_d = hold_count_q;
    m_valid_d    = m_valid_q;
    m_data_d     = m_data_q;
    m_count_d    = m_count_q;

    if (m_valid_q && bus.m_ready) begin
      m_valid_d = 1'b0;
    end

    case (state_q)
      StFill: begin
        if (in_beat) begin
          if (close) begin
            idx_d = '0;
            if (out_free) begin
              m_data_d  = packed_vec;
              m_count_d = close_count;
              m_valid_d = 1'b1;
              buf_d     = '0;
            end else begin
              // Output still occupied: park the finished vector and stall the input.
              buf_d        = packed_vec;
              hold_count_d = close_count;
              state_d      = StHold;
            end
          end else begin
            buf_d[idx_q*WIDTH +: WIDTH] = bus.s_data;
            idx_d                       = idx_q + 1'b1;
          end
        end
      end
      StHold: begin
        if (m_valid_q && bus.m_ready) begin
          m_data_d  = buf_q;
          m_count_d = hold_count_q;
          m_valid_d = 1'b1;
          buf_d     = '0;
          state_d   = StFill;
        end
      end
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StFill;
      idx_q        <= '0;
      buf_q        <= '0;
      hold_count_q <= '0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      m_count_q    <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      buf_q        <= buf_d;
      hold_count_q <= hold_count_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      m_count_q    <= m_count_d;
    end
  end
endmodule

// File: tb/tb_vec_packer.sv
// Directed bench for vec_packer: expected vectors queued at stimulus time, checked by a monitor.
module tb_vec_packer;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned SIZE  = 2;

  typedef struct {
    logic [31:0] data;
    logic [2:0]  count;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t exp_q[$];

  vec_packer_if #(.WIDTH(WIDTH), .SIZE(SIZE)) bus ();

  vec_packer #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] data, input logic [2:0] count);
    exp_t e;
    e.data  = data;
    e.count = count;
    exp_q.push_back(e);
  endtask

  // Presents one sample until accepted; returns #1 after the accepting edge.
  task automatic send(input logic [7:0] data, input logic last, output int stalls);
    logic rdy;
    stalls      = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = data;
    bus.s_last  = last;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      rdy = bus.s_ready;
      @(posedge clk);
      #1;
      if (rdy) return;
      stalls++;
    end
    errors++;
    checks++;
    $display("FAIL send_timeout: sample %0h not accepted after 200 cycles", data);
  endtask

  task automatic idle();
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    bus.s_data  = '0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 50; i++) begin
      if (exp_q.size() == 0 && !bus.m_valid) break;
      @(posedge clk);
      #1;
    end
    chk("drained", 64'(exp_q.size()), 64'd0);
  endtask

  // Scoreboard monitor: compares every accepted output vector against the queue head.
  always @(negedge clk) begin
    if (rst_n && bus.m_valid && bus.m_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_vector: got data %0h count %0d, none expected",
                 bus.m_data, bus.m_count);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (bus.m_data !== e.data || bus.m_count !== e.count) begin
          errors++;
          $display("FAIL vector: got data %0h count %0d expected data %0h count %0d",
                   bus.m_data, bus.m_count, e.data, e.count);
        end
      end
    end
  end

  initial begin
    int st;
    int total_stalls;
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    bus.m_ready = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_m_valid", 64'(bus.m_valid), 64'd0);
    chk("reset_m_data", 64'(bus.m_data), 64'd0);
    chk("reset_m_count", 64'(bus.m_count), 64'd0);
    chk("reset_s_ready", 64'(bus.s_ready), 64'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: full vector, latency 1 from last beat
    push(32'h44332211, 3'd4);
    send(8'h11, 1'b0, st);
    send(8'h22, 1'b0, st);
    send(8'h33, 1'b0, st);
    send(8'h44, 1'b0, st);
    chk("t1_m_valid_latency", 64'(bus.m_valid), 64'd1);
    idle();
    wait_drain();

    // 2: early close with s_last
    push(32'h0000BBAA, 3'd2);
    send(8'hAA, 1'b0, st);
    send(8'hBB, 1'b1, st);
    idle();
    wait_drain();

    // 3: backpressure into HOLD, then release (also shows restart at lane 0)
    bus.m_ready = 1'b0;
    push(32'h04030201, 3'd4);
    push(32'h08070605, 3'd4);
    for (int i = 1; i <= 8; i++) send(8'(i), 1'b0, st);
    idle();
    chk("t3_hold_s_ready", 64'(bus.s_ready), 64'd0);
    chk("t3_held_m_data", 64'(bus.m_data), 64'h04030201);
    @(posedge clk);
    #1;
    chk("t3_hold_stable", 64'(bus.m_data), 64'h04030201);
    bus.m_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("t3_reload_m_data", 64'(bus.m_data), 64'h08070605);
    chk("t3_reload_m_valid", 64'(bus.m_valid), 64'd1);
    chk("t3_s_ready_back", 64'(bus.s_ready), 64'd1);
    wait_drain();

    // 4: continuous stream, no stalls
    total_stalls = 0;
    push(32'h13121110, 3'd4);
    push(32'h17161514, 3'd4);
    push(32'h1B1A1918, 3'd4);
    for (int i = 0; i < 12; i++) begin
      send(8'(8'h10 + i), 1'b0, st);
      total_stalls += st;
    end
    idle();
    chk("t4_no_stalls", 64'(total_stalls), 64'd0);
    wait_drain();

    // 5: reset mid-vector discards partial lanes
    send(8'hEE, 1'b0, st);
    send(8'hEF, 1'b0, st);
    idle();
    rst_n = 1'b0;
    #2;
    chk("t5_reset_m_valid", 64'(bus.m_valid), 64'd0);
    @(posedge clk);
    #1;
    chk("t5_reset_s_ready", 64'(bus.s_ready), 64'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    push(32'hF3F2F1F0, 3'd4);
    for (int i = 0; i < 4; i++) send(8'(8'hF0 + i), 1'b0, st);
    idle();
    wait_drain();

    // 6: s_last on the very first sample
    push(32'h0000005A, 3'd1);
    send(8'h5A, 1'b1, st);
    idle();
    wait_drain();
    chk("final_m_valid_low", 64'(bus.m_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
